mc_decode_fsm: RTL

//  Multicycle control unit for the ARM datapath: a Moore state machine sequences each

---
 rtl/mc_decode_fsm_pkg.sv | 45 ++++
 rtl/mc_decode_fsm_if.sv | 39 +++
 rtl/mc_decode_fsm_alu_decoder.sv | 41 ++++
 rtl/mc_decode_fsm.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/mc_decode_fsm_pkg.sv
// Shared encodings for the multicycle ARM control unit: FSM states, ALU
// command field values, ALU control codes and instruction Op classes.
package mc_decode_fsm_pkg;

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXECR  = 4'd6,
      S_EXECI  = 4'd7,
      S_ALUWB  = 4'd8,
      S_BRANCH = 4'd9
   } state_t;

   // Instruction Op field (Instr[27:26])
   localparam logic [1:0] OP_DP  = 2'b00;
   localparam logic [1:0] OP_MEM = 2'b01;
   localparam logic [1:0] OP_BR  = 2'b10;

   // Data-processing cmd field (Funct[4:1])
   localparam logic [3:0] CMD_AND = 4'b0000;
   localparam logic [3:0] CMD_EOR = 4'b0001;
   localparam logic [3:0] CMD_SUB = 4'b0010;
   localparam logic [3:0] CMD_ADD = 4'b0100;
   localparam logic [3:0] CMD_CMP = 4'b1010;
   localparam logic [3:0] CMD_ORR = 4'b1100;
   localparam logic [3:0] CMD_MOV = 4'b1101;

   // ALU control codes, zero-extended to ALUCTL_W at the decoder output
   localparam logic [2:0] ALU_ADD = 3'd0;
   localparam logic [2:0] ALU_SUB = 3'd1;
   localparam logic [2:0] ALU_AND = 3'd2;
   localparam logic [2:0] ALU_ORR = 3'd3;
   localparam logic [2:0] ALU_EOR = 3'd6;
   localparam logic [2:0] ALU_MOV = 3'd7;

   // States that wait on the memory and therefore run the wait counter
   function automatic logic is_wait_state(state_t s);
      return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
   endfunction

endpackage

// File: rtl/mc_decode_fsm_if.sv
// Bundle between instruction register / memory (master side) and the control
// unit (slave side).
// Handshake: MemReady is a level from memory; an access in FETCH, MEMRD or
// MEMWR completes in the cycle MemReady is sampled high at the rising edge,
// and the FSM leaves that state on that edge. There is no ready back-pressure
// toward the memory: MemW/IRWrite simply follow MemReady inside their state.
interface mc_decode_fsm_if #(parameter int ALUCTL_W = 4);
   logic [1:0]          Op;
   logic [5:0]          Funct;
   logic [3:0]          Rd;
   logic                MemReady;
   logic                IRWrite;
   logic                NextPC;
   logic                AdrSrc;
   logic [1:0]          ALUSrcA;
   logic [1:0]          ALUSrcB;
   logic [1:0]          ResultSrc;
   logic [1:0]          ImmSrc;
   logic [1:0]          RegSrc;
   logic                RegW;
   logic                MemW;
   logic                PCS;
   logic [1:0]          FlagW;
   logic [ALUCTL_W-1:0] ALUControl;
   logic                MemTimeout;
   logic [3:0]          State;

   modport master (
      output Op, Funct, Rd, MemReady,
      input  IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc,
             RegSrc, RegW, MemW, PCS, FlagW, ALUControl, MemTimeout, State
   );

   modport slave (
      input  Op, Funct, Rd, MemReady,
      output IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc,
             RegSrc, RegW, MemW, PCS, FlagW, ALUControl, MemTimeout, State
   );
endinterface

// File: rtl/mc_decode_fsm_alu_decoder.sv
// Combinational ALU decoder: maps the data-processing cmd and S bit to an
// ALU control code, flag-write enables and the NoWrite (no writeback) flag.
// Only active while the FSM is in an execute state (alu_op=1).
module mc_alu_decoder
   import mc_decode_fsm_pkg::*;
#(
   parameter int ALUCTL_W = 4
) (
   input  logic                alu_op,
   input  logic [3:0]          cmd,
   input  logic                s_bit,
   output logic [ALUCTL_W-1:0] alu_control,
   output logic [1:0]          flag_w,
   output logic                no_write
);

   logic [2:0] code;

   // Decode cmd; unsupported commands become a flagless NOP with no writeback
   always_comb begin
      code     = ALU_ADD;
      flag_w   = 2'b00;
      no_write = 1'b0;
      if (alu_op) begin
         case (cmd)
            CMD_ADD: begin code = ALU_ADD; flag_w = {s_bit, s_bit}; end
            CMD_SUB: begin code = ALU_SUB; flag_w = {s_bit, s_bit}; end
            CMD_AND: begin code = ALU_AND; flag_w = {s_bit, 1'b0};  end
            CMD_ORR: begin code = ALU_ORR; flag_w = {s_bit, 1'b0};  end
            CMD_EOR: begin code = ALU_EOR; flag_w = {s_bit, 1'b0};  end
            CMD_MOV: begin code = ALU_MOV; flag_w = {s_bit, 1'b0};  end
            // CMP exists only for its flags, so it sets them regardless of S
            CMD_CMP: begin code = ALU_SUB; flag_w = 2'b11; no_write = 1'b1; end
            default: begin code = ALU_ADD; flag_w = 2'b00; no_write = 1'b1; end
         endcase
      end
   end

   assign alu_control = ALUCTL_W'(code);

endmodule

// File: rtl/mc_decode_fsm.sv
// Multicycle ARM control unit: Moore FSM sequencing fetch/decode/execute/
// memory/writeback, with memory wait states, a sticky timeout flag and the
// ALU decoder as a sub-block. Outputs decode from the registered state.
module mc_decode_fsm
   import mc_decode_fsm_pkg::*;
#(
   parameter int ALUCTL_W = 4,
   parameter int WAIT_EN  = 1,
   parameter int WAIT_MAX = 15
) (
   input logic           clk,
   input logic           reset,
   mc_decode_fsm_if.slave bus
);

   localparam int CNT_W = $clog2(WAIT_MAX + 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             tmo_q, tmo_d;

   logic             mem_rdy;
   logic             alu_op;
   logic             no_write;
   logic             reg_w, mem_w, branch, ir_write, adr_src;
   logic [1:0]       alu_src_a, alu_src_b, result_src;

   // With waits disabled every memory access is treated as completing at once
   assign mem_rdy = (WAIT_EN != 0) ? bus.MemReady : 1'b1;
   assign alu_op  = (state_q == S_EXECR) || (state_q == S_EXECI);

   mc_alu_decoder #(.ALUCTL_W(ALUCTL_W)) u_alu_dec (
      .alu_op      (alu_op),
      .cmd         (bus.Funct[4:1]),
      .s_bit       (bus.Funct[0]),
      .alu_control (bus.ALUControl),
      .flag_w      (bus.FlagW),
      .no_write    (no_write)
   );

   // Next state, wait counter and timeout; a timeout abandons the instruction
   always_comb begin
      state_d = state_q;
      cnt_d   = '0;
      tmo_d   = tmo_q;
      case (state_q)
         S_FETCH:  if (mem_rdy) state_d = S_DECODE;
         S_DECODE: begin
            case (bus.Op)
               OP_MEM:  state_d = S_MEMADR;
               OP_DP:   state_d = bus.Funct[5] ? S_EXECI : S_EXECR;
               OP_BR:   state_d = S_BRANCH;
               default: state_d = S_FETCH;
            endcase
         end
         S_MEMADR: state_d = bus.Funct[0] ? S_MEMRD : S_MEMWR;
         S_MEMRD:  if (mem_rdy) state_d = S_MEMWB;
         S_MEMWB:  state_d = S_FETCH;
         S_MEMWR:  if (mem_rdy) state_d = S_FETCH;
         S_EXECR,
         S_EXECI:  state_d = no_write ? S_FETCH : S_ALUWB;
         S_ALUWB:  state_d = S_FETCH;
         S_BRANCH: state_d = S_FETCH;
         default:  state_d = S_FETCH;
      endcase
      // Counter only survives while stalling in the same wait state, so any
      // entry (including FETCH after a timeout) starts it from zero
      if (is_wait_state(state_q) && !mem_rdy) begin
         if (cnt_q == CNT_W'(WAIT_MAX - 1)) begin
            tmo_d   = 1'b1;
            state_d = S_FETCH;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   // State, wait count and sticky timeout registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_FETCH;
         cnt_q   <= '0;
         tmo_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         tmo_q   <= tmo_d;
      end
   end

   // Per-state datapath selects; everything not named in a state stays 0
   always_comb begin
      ir_write   = 1'b0;
      adr_src    = 1'b0;
      alu_src_a  = 2'b00;
      alu_src_b  = 2'b00;
      result_src = 2'b00;
      reg_w      = 1'b0;
      mem_w      = 1'b0;
      branch     = 1'b0;
      case (state_q)
         S_FETCH: begin
            alu_src_a  = 2'b01;
            alu_src_b  = 2'b10;
            result_src = 2'b10;
            ir_write   = mem_rdy & ~reset;
         end
         S_DECODE: begin
            alu_src_a  = 2'b01;
            alu_src_b  = 2'b10;
            result_src = 2'b10;
         end
         S_MEMADR: alu_src_b = 2'b01;
         S_MEMRD:  adr_src = 1'b1;
         S_MEMWB: begin
            result_src = 2'b01;
            reg_w      = 1'b1;
         end
         S_MEMWR: begin
            adr_src = 1'b1;
            mem_w   = mem_rdy;
         end
         S_EXECR:  alu_src_b = 2'b00;
         S_EXECI:  alu_src_b = 2'b01;
         S_ALUWB:  reg_w = 1'b1;
         S_BRANCH: begin
            alu_src_b  = 2'b01;
            result_src = 2'b10;
            branch     = 1'b1;
         end
         default: ;
      endcase
   end

   assign bus.IRWrite    = ir_write;
   assign bus.NextPC     = ir_write;
   assign bus.AdrSrc     = adr_src;
   assign bus.ALUSrcA    = alu_src_a;
   assign bus.ALUSrcB    = alu_src_b;
   assign bus.ResultSrc  = result_src;
   assign bus.RegW       = reg_w;
   assign bus.MemW       = mem_w;
   assign bus.PCS        = ((bus.Rd == 4'hF) & reg_w) | branch;
   assign bus.ImmSrc     = (bus.Op == OP_MEM) ? 2'b01 :
                           (bus.Op == OP_BR)  ? 2'b10 : 2'b00;
   assign bus.RegSrc     = {bus.Op == OP_MEM, bus.Op == OP_BR};
   assign bus.MemTimeout = tmo_q;
   assign bus.State      = state_q;

endmodule
